// File: rtl/axi_host_mem_pkg.sv
// Shared definitions for the AXI host-memory bridge: response codes and FSM state types.
package axi_host_mem_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_ISSUE
  } rd_state_t;

endpackage

// File: rtl/axi_host_mem_rd_fifo.sv
// Two-entry read return FIFO holding data, last flag and response per beat.
// The count output lets the issuer budget memory reads against free slots.
module axi_host_mem_rd_fifo
  import axi_host_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 512
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  push_last,
  input  logic [1:0]            push_resp,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  head_last,
  output logic [1:0]            head_resp,
  output logic                  not_empty,
  output logic [1:0]            count
);

  logic [DATA_WIDTH-1:0] data_q [2];
  logic                  last_q [2];
  logic [1:0]            resp_q [2];
  logic                  wr_ptr;
  logic                  rd_ptr;

  // Storage and pointer update; push and pop may coincide even when full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) begin
        data_q[i] <= '0;
        last_q[i] <= 1'b0;
        resp_q[i] <= RESP_OKAY;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        data_q[wr_ptr] <= push_data;
        last_q[wr_ptr] <= push_last;
        resp_q[wr_ptr] <= push_resp;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(push) - 2'(pop);
    end
  end

  // Head entry presented directly to the R channel.
  always_comb begin
    head_data = data_q[rd_ptr];
    head_last = last_q[rd_ptr];
    head_resp = resp_q[rd_ptr];
    not_empty = (count != 2'd0);
  end

endmodule

// File: rtl/axi_host_mem_bridge.sv
// AXI4 slave (INCR, full-width beats, single ID) driving one port of the host memory model.
// Optional feature: define HOST_MEM_RANGE_CHECK_EN to suppress beats at or above HOST_MEM_SIZE
// and answer those bursts with SLVERR.
module axi_host_mem_bridge
  import axi_host_mem_pkg::*;
#(
  parameter int              DATA_WIDTH    = 512,
  parameter int              ADDR_WIDTH    = 64,
  parameter int              MASK_WIDTH    = DATA_WIDTH / 8,
  parameter longint unsigned HOST_MEM_SIZE = 1048576
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [MASK_WIDTH-1:0] s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic [MASK_WIDTH-1:0] mem_wr_datastrb,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  input  logic                  mem_rd_data_vld
);

  localparam logic [ADDR_WIDTH-1:0] STEP  = ADDR_WIDTH'(MASK_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ALIGN = ~(STEP - ADDR_WIDTH'(1));

  wr_state_t             wr_state;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [7:0]            wr_len;
  logic [7:0]            wr_cnt;
  logic                  wr_err;
  logic                  wr_oob;
  logic                  wr_fire;
  logic                  beat_last;
  logic                  beat_err;

  rd_state_t             rd_state;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [7:0]            rd_len;
  logic [7:0]            rd_cnt;
  logic                  rd_err;
  logic                  rd_oob;
  logic [1:0]            inflight;
  logic                  pend_fake;
  logic                  pend_last;
  logic [1:0]            pend_resp;
  logic [1:0]            fifo_count;
  logic [2:0]            occupancy;
  logic                  credit_ok;
  logic                  issue;
  logic                  issue_last;
  logic [1:0]            issue_resp;
  logic                  rd_push;
  logic                  rd_pop;

`ifdef HOST_MEM_RANGE_CHECK_EN
  localparam logic [ADDR_WIDTH-1:0] MEM_LIMIT = ADDR_WIDTH'(HOST_MEM_SIZE);
  assign wr_oob = (wr_addr >= MEM_LIMIT);
  assign rd_oob = (rd_addr >= MEM_LIMIT);
`else
  assign wr_oob = 1'b0;
  assign rd_oob = 1'b0;
`endif

  // Per-beat write qualification: final-beat detection and error accumulation.
  always_comb begin
    wr_fire   = s_axi_wvalid && s_axi_wready;
    beat_last = (wr_cnt == wr_len);
    beat_err  = wr_err || wr_oob || (s_axi_wlast != beat_last);
  end

  // Write FSM: accept AW, stream W beats to memory with one-cycle latency, then respond.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state        <= W_IDLE;
      s_axi_awready   <= 1'b0;
      s_axi_wready    <= 1'b0;
      s_axi_bvalid    <= 1'b0;
      s_axi_bresp     <= RESP_OKAY;
      wr_addr         <= '0;
      wr_len          <= '0;
      wr_cnt          <= '0;
      wr_err          <= 1'b0;
      mem_wr_data     <= '0;
      mem_wr_datastrb <= '0;
      mem_wr_addr     <= '0;
    end else begin
      mem_wr_datastrb <= '0;
      case (wr_state)
        W_IDLE: begin
          s_axi_awready <= 1'b1;
          if (s_axi_awvalid && s_axi_awready) begin
            wr_addr       <= s_axi_awaddr & ALIGN;
            wr_len        <= s_axi_awlen;
            wr_cnt        <= '0;
            wr_err        <= 1'b0;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b1;
            wr_state      <= W_DATA;
          end
        end
        W_DATA: begin
          if (wr_fire) begin
            mem_wr_data     <= s_axi_wdata;
            mem_wr_datastrb <= wr_oob ? '0 : s_axi_wstrb;
            mem_wr_addr     <= wr_addr;
            wr_addr         <= wr_addr + STEP;
            wr_cnt          <= wr_cnt + 8'd1;
            wr_err          <= beat_err;
            if (beat_last || s_axi_wlast) begin
              s_axi_wready <= 1'b0;
              s_axi_bvalid <= 1'b1;
              s_axi_bresp  <= beat_err ? RESP_SLVERR : RESP_OKAY;
              wr_state     <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid  <= 1'b0;
            s_axi_awready <= 1'b1;
            wr_state      <= W_IDLE;
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  // Read issue decision. The R-channel pop in the same cycle counts as a freed
  // credit, so mem_rd_en is decoded from registered state rather than registered
  // itself; this keeps one beat per clock with only two FIFO entries.
  always_comb begin
    rd_pop     = s_axi_rvalid && s_axi_rready;
    rd_push    = mem_rd_data_vld || pend_fake;
    occupancy  = {1'b0, fifo_count} + {1'b0, inflight};
    credit_ok  = (occupancy < (3'd2 + {2'b00, rd_pop}));
    issue      = (rd_state == R_ISSUE) && credit_ok;
    issue_last = (rd_cnt == rd_len);
    issue_resp = (rd_err || rd_oob) ? RESP_SLVERR : RESP_OKAY;
    mem_rd_en  = issue && !rd_oob;
    mem_rd_addr = rd_addr;
  end

  // Read FSM: accept AR, issue one memory read per credit, track returns in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state      <= R_IDLE;
      s_axi_arready <= 1'b0;
      rd_addr       <= '0;
      rd_len        <= '0;
      rd_cnt        <= '0;
      rd_err        <= 1'b0;
      inflight      <= '0;
      pend_fake     <= 1'b0;
      pend_last     <= 1'b0;
      pend_resp     <= RESP_OKAY;
    end else begin
      inflight  <= inflight + 2'(issue) - 2'(rd_push);
      pend_fake <= issue && rd_oob;
      if (issue) begin
        pend_last <= issue_last;
        pend_resp <= issue_resp;
      end
      case (rd_state)
        R_IDLE: begin
          s_axi_arready <= 1'b1;
          if (s_axi_arvalid && s_axi_arready) begin
            rd_addr       <= s_axi_araddr & ALIGN;
            rd_len        <= s_axi_arlen;
            rd_cnt        <= '0;
            rd_err        <= 1'b0;
            s_axi_arready <= 1'b0;
            rd_state      <= R_ISSUE;
          end
        end
        R_ISSUE: begin
          if (issue) begin
            rd_addr <= rd_addr + STEP;
            rd_cnt  <= rd_cnt + 8'd1;
            rd_err  <= rd_err || rd_oob;
            if (issue_last) begin
              s_axi_arready <= 1'b1;
              rd_state      <= R_IDLE;
            end
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  axi_host_mem_rd_fifo #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_rd_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rd_push),
    .push_data (pend_fake ? '0 : mem_rd_data),
    .push_last (pend_last),
    .push_resp (pend_resp),
    .pop       (rd_pop),
    .head_data (s_axi_rdata),
    .head_last (s_axi_rlast),
    .head_resp (s_axi_rresp),
    .not_empty (s_axi_rvalid),
    .count     (fifo_count)
  );

endmodule
